// File: rtl/bus_timer.sv
// Memory-mapped prescaled timer with compare match, auto-reload and a write-1-to-clear match flag.
// Reads are combinational, writes land on the rising edge, and the bus never stalls.
`timescale 1ns/1ps
module bus_timer (
  input  logic        clk,
  input  logic        reset,
  input  logic        busSel,
  input  logic        busWe,
  input  logic [31:0] busAddr,
  input  logic [2:0]  strb,
  input  logic [31:0] busWData,
  output logic [31:0] busRData,
  output logic        irq
);

  localparam logic [2:0] REG_CTRL   = 3'd0;
  localparam logic [2:0] REG_PSC    = 3'd1;
  localparam logic [2:0] REG_CMP    = 3'd2;
  localparam logic [2:0] REG_CNT    = 3'd3;
  localparam logic [2:0] REG_STATUS = 3'd4;

  logic [2:0]  ctrl;
  logic [15:0] psc;
  logic [31:0] cmp;
  logic [31:0] cnt;
  logic        match;
  logic [15:0] pcnt;

  logic [3:0]  be;
  logic [31:0] wmask;
  logic [2:0]  rsel;
  logic        wr;
  logic        wr_ctrl, wr_psc, wr_cmp, wr_cnt, wr_status;
  logic        en, tick, cnt_hit, match_set, match_clr;
  logic        unused_bits;

  assign unused_bits = ^{busAddr[31:5], strb[2]};

  always_comb begin
    be = 4'b0000;
    case (strb[1:0])
      2'b00:   be = 4'b0001 << busAddr[1:0];
      2'b01:   be = busAddr[1] ? 4'b1100 : 4'b0011;
      2'b10:   be = 4'b1111;
      default: be = 4'b0000;
    endcase
  end

  assign wmask = {{8{be[3]}}, {8{be[2]}}, {8{be[1]}}, {8{be[0]}}};
  assign rsel  = busAddr[4:2];
  assign wr    = busSel & busWe;

  assign wr_ctrl   = wr && (rsel == REG_CTRL);
  assign wr_psc    = wr && (rsel == REG_PSC);
  assign wr_cmp    = wr && (rsel == REG_CMP);
  assign wr_cnt    = wr && (rsel == REG_CNT);
  assign wr_status = wr && (rsel == REG_STATUS);

  assign en        = ctrl[0];
  assign tick      = en && (pcnt == psc);
  assign cnt_hit   = (cnt == cmp);
  assign match_set = tick && cnt_hit;
  assign match_clr = wr_status && be[0] && busWData[0];

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      ctrl  <= '0;
      psc   <= '0;
      cmp   <= '0;
      cnt   <= '0;
      match <= 1'b0;
      pcnt  <= '0;
    end else begin
      if (wr_ctrl) ctrl <= (ctrl & ~wmask[2:0]) | (busWData[2:0] & wmask[2:0]);
      if (wr_psc)  psc  <= (psc & ~wmask[15:0]) | (busWData[15:0] & wmask[15:0]);
      if (wr_cmp)  cmp  <= (cmp & ~wmask) | (busWData & wmask);

      // A bus write to CNT wins over the tick and restarts the prescaler phase.
      if (wr_cnt) begin
        cnt  <= (cnt & ~wmask) | (busWData & wmask);
        pcnt <= '0;
      end else begin
        if (tick) cnt <= (cnt_hit && ctrl[1]) ? 32'h0 : cnt + 32'h1;
        if (en)   pcnt <= tick ? 16'h0 : pcnt + 16'h1;
      end

      if (match_set)      match <= 1'b1;
      else if (match_clr) match <= 1'b0;
    end
  end

  assign irq = match & ctrl[2];

  always_comb begin
    busRData = 32'h0;
    if (busSel) begin
      case (rsel)
        REG_CTRL:   busRData = {29'h0, ctrl};
        REG_PSC:    busRData = {16'h0, psc};
        REG_CMP:    busRData = cmp;
        REG_CNT:    busRData = cnt;
        REG_STATUS: busRData = {31'h0, match};
        default:    busRData = 32'h0;
      endcase
    end
  end

endmodule
